parallel_byte_receiver: RTL and testbench

Receiving end of the 8-bit parallel byte-stream link: an external transmitter drives a byte bus plus a strobe whose rising edge marks a valid byte, and the stream ends with a zero byte, a silent strobe, or a full buffer. This block synchronises the asynchronous strobe, captures each byte into an on-chip frame buffer, and reports frame completion. It also exposes the buffer through a registered read port for the CPU or host logic, with an acknowledge that releases the buffer for the next frame.

---
 rtl/parallel_byte_receiver_pkg.sv | 18 +
 rtl/parallel_byte_receiver_if.sv | 26 ++
 rtl/parallel_byte_receiver_rx_edge_sync.sv | 32 +++
 rtl/parallel_byte_receiver.sv | 149 ++++++++++++++
 tb/tb_parallel_byte_receiver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/parallel_byte_receiver_pkg.sv
// Shared definitions for the parallel byte receiver: FSM state encoding,
// synchroniser depth, default buffer size and the frame terminator test.
package parallel_byte_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_t;

    localparam int SYNC_STAGES   = 3;
    localparam int DEFAULT_DEPTH = 1025;

    function automatic logic is_terminator(input logic [7:0] b);
        return b == 8'h00;
    endfunction

endpackage

// File: rtl/parallel_byte_receiver_if.sv
// Link, read-port and frame-status signals of the parallel byte receiver.
// master = transmitter/host side, slave = the receiver itself.
interface parallel_byte_receiver_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        rx_data;
    logic              rx_strobe;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_valid;
    logic [ADDR_W-1:0] frame_len;
    logic              frame_full;
    logic              frame_dropped;
    logic              frame_ack;
    logic              busy;

    modport master (
        output rx_data, rx_strobe, rd_addr, frame_ack,
        input  rd_data, frame_valid, frame_len, frame_full, frame_dropped, busy
    );

    modport slave (
        input  rx_data, rx_strobe, rd_addr, frame_ack,
        output rd_data, frame_valid, frame_len, frame_full, frame_dropped, busy
    );
endinterface

// File: rtl/parallel_byte_receiver_rx_edge_sync.sv
// Strobe synchroniser, data alignment and strobe rising-edge detection.
// d2 lines up with rise so the byte can be written on the edge that sees rise.
module rx_edge_sync
    import parallel_byte_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic       rise,
    output logic [7:0] d2
);

    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [7:0]             d1;

    // Chain resets to all ones so a strobe held high across reset is not a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_sync <= '1;
            d1          <= 8'h00;
            d2          <= 8'h00;
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], rx_strobe};
            d1          <= rx_data;
            d2          <= d1;
        end
    end

    assign rise = strobe_sync[SYNC_STAGES-2] & ~strobe_sync[SYNC_STAGES-1];

endmodule

// File: rtl/parallel_byte_receiver.sv
// Parallel byte-stream receiver: captures a frame into a buffer with a registered read port.
// Optional idle timeout that closes a silent frame: define RX_TIMEOUT_EN.
module parallel_byte_receiver
    import parallel_byte_receiver_pkg::*;
#(
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int ADDR_W         = 11,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TIMEOUT_W      = 24
) (
    input logic clk,
    input logic rst,
    parallel_byte_receiver_if.slave bus
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    rx_state_t         state, state_next;
    logic              rise;
    logic [7:0]        d2;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_inc, frame_len_q;
    logic              frame_full_q, frame_dropped_q;
    logic              timeout;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              frame_valid_c, busy_c;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem [0:DEPTH-1];

    rx_edge_sync u_edge_sync (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (bus.rx_data),
        .rx_strobe (bus.rx_strobe),
        .rise      (rise),
        .d2        (d2)
    );

    assign wr_ptr_inc = wr_ptr + ADDR_W'(1);

`ifdef RX_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] idle_cnt;

    // Held at zero outside RECV, so it is already clear on entry to RECV.
    always_ff @(posedge clk) begin
        if (rst || state != RECV || rise)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TIMEOUT_W'(1);
    end

    assign timeout = (state == RECV) && !rise && (idle_cnt == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rise && !is_terminator(d2)) state_next = RECV;
            RECV: begin
                if (rise) begin
                    if (is_terminator(d2) || wr_ptr_inc == DEPTH_A) state_next = DONE;
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            DONE: if (bus.frame_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_valid_c = (state == DONE);
        busy_c        = (state == RECV);
        mem_we        = rise && !is_terminator(d2) && (state == IDLE || state == RECV);
        mem_waddr     = (state == IDLE) ? '0 : wr_ptr;
    end

    // An ack in DONE takes priority over a byte arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            frame_len_q     <= '0;
            frame_full_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_we) wr_ptr <= ADDR_W'(1);
                RECV: begin
                    if (rise) begin
                        if (is_terminator(d2)) begin
                            frame_len_q <= wr_ptr;
                        end else begin
                            wr_ptr <= wr_ptr_inc;
                            if (wr_ptr_inc == DEPTH_A) begin
                                frame_len_q  <= wr_ptr_inc;
                                frame_full_q <= 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        frame_len_q <= wr_ptr;
                    end
                end
                DONE: begin
                    if (bus.frame_ack) begin
                        wr_ptr          <= '0;
                        frame_len_q     <= '0;
                        frame_full_q    <= 1'b0;
                        frame_dropped_q <= 1'b0;
                    end else if (rise) begin
                        frame_dropped_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= d2;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data_q <= 8'h00;
        else if (bus.rd_addr < DEPTH_A)
            rd_data_q <= mem[bus.rd_addr];
        else
            rd_data_q <= 8'h00;
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.frame_valid   = frame_valid_c;
    assign bus.frame_len     = frame_len_q;
    assign bus.frame_full    = frame_full_q;
    assign bus.frame_dropped = frame_dropped_q;
    assign bus.busy          = busy_c;

endmodule

// File: tb/tb_parallel_byte_receiver.sv
// Self-checking bench for parallel_byte_receiver: table vectors, corner sequences
// and random frames compared against a queue-based frame model.
module tb_parallel_byte_receiver;

    localparam int DEPTH  = 1025;
    localparam int ADDR_W = 11;
    localparam int TCYC   = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parallel_byte_receiver_if #(.ADDR_W(ADDR_W)) bus ();

    parallel_byte_receiver #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TCYC),
        .TIMEOUT_W      (24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] data;
        bit         expBusy;
        bit         expValid;
        int         expLen;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model: the buffer image plus the bytes of the current frame.
    logic [7:0] modelMem [0:DEPTH-1];
    logic [7:0] frameQ [$];
    bit frameOpen, frameClosed, frameDropped;

    function automatic void modelReset();
        frameQ.delete();
        frameOpen    = 0;
        frameClosed  = 0;
        frameDropped = 0;
    endfunction

    function automatic void modelPush(input logic [7:0] b);
        if (frameClosed) begin
            frameDropped = 1;
        end else if (b == 8'h00) begin
            if (frameOpen) frameClosed = 1;
        end else begin
            modelMem[frameQ.size()] = b;
            frameQ.push_back(b);
            frameOpen = 1;
            if (frameQ.size() == DEPTH) frameClosed = 1;
        end
    endfunction

    function automatic void modelAck();
        if (frameClosed) modelReset();
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " busy"},    int'(bus.busy),          int'(frameOpen && !frameClosed));
        checkOutput({tag, " valid"},   int'(bus.frame_valid),   int'(frameClosed));
        checkOutput({tag, " len"},     int'(bus.frame_len),     frameClosed ? frameQ.size() : 0);
        checkOutput({tag, " full"},    int'(bus.frame_full),    int'(frameClosed && frameQ.size() == DEPTH));
        checkOutput({tag, " dropped"}, int'(bus.frame_dropped), int'(frameDropped));
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int phase);
        @(negedge clk);
        bus.rx_data = b;
        @(negedge clk);
        bus.rx_strobe = 1'b1;
        repeat (phase) @(negedge clk);
        bus.rx_strobe = 1'b0;
        repeat (phase) @(negedge clk);
        modelPush(b);
    endtask

    task automatic readCheck(input string name, input int addr, input int expected);
        @(negedge clk);
        bus.rd_addr = ADDR_W'(addr);
        @(negedge clk);
        checkOutput(name, int'(bus.rd_data), expected);
    endtask

    task automatic pulseAck();
        @(negedge clk);
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        modelAck();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        int   len;
        int   phase;
        logic [7:0] b;

        vecs[0] = '{8'h00, 1'b0, 1'b0, 0};
        vecs[1] = '{8'h48, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h69, 1'b1, 1'b0, 0};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 2};

        rst = 1'b1;
        bus.rx_data   = 8'h00;
        bus.rx_strobe = 1'b0;
        bus.rd_addr   = '0;
        bus.frame_ack = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkAll("reset");
        checkOutput("reset rd_data", int'(bus.rd_data), 0);
        rst = 1'b0;

        // Zero in IDLE ignored, then a two-byte frame.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].data, 6);
            checkOutput($sformatf("vec%0d busy", i),  int'(bus.busy),        int'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d valid", i), int'(bus.frame_valid), int'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d len", i),   int'(bus.frame_len),   vecs[i].expLen);
            checkAll($sformatf("vec%0d model", i));
        end
        readCheck("hello rd0", 0, 8'h48);
        readCheck("hello rd1", 1, 8'h69);

        // Byte in DONE is dropped and the buffer is untouched.
        applyStimulus(8'h55, 4);
        checkAll("drop");
        readCheck("drop rd0", 0, 8'h48);
        readCheck("drop rd1", 1, 8'h69);
        readCheck("drop rd2", 2, 8'h00 + int'(modelMem[2] === 8'hxx ? 8'h00 : modelMem[2]));
        pulseAck();
        checkAll("ack");

        // Strobe held high across reset release.
        @(negedge clk);
        rst = 1'b1;
        bus.rx_data   = 8'h77;
        bus.rx_strobe = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
        repeat (8) @(negedge clk);
        checkAll("strobe thru reset");
        bus.rx_strobe = 1'b0;
        repeat (4) @(negedge clk);
        checkAll("strobe thru reset low");

        // Reset mid-frame; next frame restarts at address 0, old bytes stay.
        applyStimulus(8'hA1, 4);
        applyStimulus(8'hA2, 4);
        applyStimulus(8'hA3, 4);
        checkAll("midframe");
        doReset();
        checkAll("after reset");
        applyStimulus(8'h11, 4);
        applyStimulus(8'h00, 4);
        checkAll("restart");
        readCheck("restart rd0", 0, 8'h11);
        readCheck("stale rd1", 1, 8'hA2);

        // Ack and byte rise in the same cycle: ack wins, no drop flag.
        @(negedge clk);
        bus.rx_data = 8'h33;
        @(negedge clk);
        bus.rx_strobe = 1'b1;
        repeat (2) @(negedge clk);
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        modelAck();
        checkAll("ack+rise");
        bus.rx_strobe = 1'b0;
        repeat (4) @(negedge clk);
        checkAll("ack+rise settle");

        // Random frames against the model.
        for (int f = 0; f < 6; f++) begin
            len   = int'($urandom_range(30, 1));
            phase = int'($urandom_range(6, 3));
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(255, 1));
                applyStimulus(b, phase);
            end
            applyStimulus(8'h00, phase);
            checkAll($sformatf("rand%0d", f));
            for (int a = 0; a < len; a++)
                readCheck($sformatf("rand%0d rd%0d", f, a), a, int'(modelMem[a]));
            pulseAck();
            checkAll($sformatf("rand%0d ack", f));
        end
        readCheck("oob rd1025", 1025, 0);
        readCheck("oob rd2047", 2047, 0);

        // Full buffer with no terminator.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(8'((i % 255) + 1), 3);
            if (i == DEPTH - 2) checkAll("full minus one");
        end
        checkAll("full");
        readCheck("full rd0", 0, 1);
        readCheck("full rd254", 254, 255);
        readCheck("full rd1024", 1024, 5);
        pulseAck();
        checkAll("full ack");

        // Silent link after two bytes.
        applyStimulus(8'h21, 4);
`ifdef RX_TIMEOUT_EN
        @(negedge clk);
        bus.rx_data = 8'h22;
        @(negedge clk);
        bus.rx_strobe = 1'b1;
        repeat (3) @(posedge clk);
        modelPush(8'h22);
        for (int k = 1; k <= TCYC - 1; k++) begin
            @(posedge clk);
            if (k == 4) begin
                #1;
                bus.rx_strobe = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("timeout not early", int'(bus.frame_valid), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("timeout fires", int'(bus.frame_valid), 1);
        frameClosed = 1;
        checkAll("timeout");
`else
        applyStimulus(8'h22, 4);
        repeat (200) @(negedge clk);
        checkAll("no timeout");
        applyStimulus(8'h00, 4);
        checkAll("no timeout close");
`endif
        readCheck("silent rd1", 1, 8'h22);
        pulseAck();
        checkAll("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
